// File: rtl/gf_matmul_scheduler.sv
// Sequential GF(2^N) matrix multiplier: one shared multiply-XOR-accumulate lane
// walks k (innermost), j, i and issues one MAC per clock; S = A*B mod p.
module gf_matmul_scheduler #(
  parameter int N     = 8,
  parameter int ROW_A = 4,
  parameter int COL_A = 4,
  parameter int COL_B = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_i,
  input  logic [ROW_A*COL_A-1:0][N-1:0]     a_i,
  input  logic [COL_A*COL_B-1:0][N-1:0]     b_i,
  input  logic [N:0]                        p_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic [ROW_A*COL_B-1:0][N-1:0]     s_o
);

  localparam int NA = ROW_A * COL_A;
  localparam int NB = COL_A * COL_B;
  localparam int NS = ROW_A * COL_B;
  localparam int IW = (ROW_A > 1) ? $clog2(ROW_A) : 1;
  localparam int JW = (COL_B > 1) ? $clog2(COL_B) : 1;
  localparam int KW = (COL_A > 1) ? $clog2(COL_A) : 1;
  localparam int AW = (NA > 1) ? $clog2(NA) : 1;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;
  localparam int PW = 2 * N - 1;

  // Encoding chosen so busy/done are single state bits.
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;

  state_t                 state_q;
  logic [NA-1:0][N-1:0]   a_q;
  logic [NB-1:0][N-1:0]   b_q;
  logic [N:0]             p_q;
  logic [IW-1:0]          i_q;
  logic [JW-1:0]          j_q;
  logic [KW-1:0]          k_q;
  logic [N-1:0]           acc_q, acc_d;
  logic [NS-1:0][N-1:0]   res_q, res_d;
  logic [NS-1:0][N-1:0]   s_q;
  logic [AW-1:0]          ia;
  logic [BW-1:0]          ib;
  logic [SW-1:0]          is;
  logic                   k_last, j_last, i_last;

  // Carry-less product, then MSB-first reduction by p aligned to each set bit.
  function automatic logic [N-1:0] gfmul(input logic [N-1:0] x, input logic [N-1:0] y,
                                         input logic [N:0] pp);
    logic [PW-1:0] prod;
    prod = '0;
    for (int t = 0; t < N; t++)
      if (y[t]) prod = prod ^ (PW'(x) << t);
    for (int t = PW - 1; t >= N; t--)
      if (prod[t]) prod = prod ^ (PW'(pp) << (t - N));
    return prod[N-1:0];
  endfunction

  always_comb begin
    ia     = AW'(i_q) * AW'(COL_A) + AW'(k_q);
    ib     = BW'(k_q) * BW'(COL_B) + BW'(j_q);
    is     = SW'(i_q) * SW'(COL_B) + SW'(j_q);
    k_last = (k_q == KW'(COL_A - 1));
    j_last = (j_q == JW'(COL_B - 1));
    i_last = (i_q == IW'(ROW_A - 1));
    acc_d  = acc_q ^ gfmul(a_q[ia], b_q[ib], p_q);
    res_d  = res_q;
    res_d[is] = acc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      s_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          a_q     <= a_i;
          b_q     <= b_i;
          p_q     <= p_i;
          i_q     <= '0;
          j_q     <= '0;
          k_q     <= '0;
          acc_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          if (k_last) begin
            k_q   <= '0;
            acc_q <= '0;
            res_q <= res_d;
            if (j_last) begin
              j_q <= '0;
              if (i_last) begin
                // Final element is folded in directly so s is complete at DONE.
                i_q     <= '0;
                s_q     <= res_d;
                state_q <= DONE;
              end else begin
                i_q <= i_q + IW'(1);
              end
            end else begin
              j_q <= j_q + JW'(1);
            end
          end else begin
            k_q   <= k_q + KW'(1);
            acc_q <= acc_d;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = state_q[0];
  assign done_o = state_q[1];
  assign s_o    = s_q;

endmodule

// File: tb/tb_gf_matmul_scheduler.sv
// Randomized bench for gf_matmul_scheduler (4x4*4x1 and 1x1 instances) against a
// shift-and-reduce GF(2^8) reference model.
module tb_gf_matmul_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             start;
  logic [15:0][7:0] a;
  logic [3:0][7:0]  b;
  logic [8:0]       p;
  logic             busy, done;
  logic [3:0][7:0]  s;

  logic             start1;
  logic [0:0][7:0]  a1, b1;
  logic [8:0]       p1;
  logic             busy1, done1;
  logic [0:0][7:0]  s1;

  int n_vec = 0;
  int n_err = 0;

  gf_matmul_scheduler #(.N(8), .ROW_A(4), .COL_A(4), .COL_B(1)) u_dut (
    .clk(clk), .rst(rst), .start_i(start), .a_i(a), .b_i(b), .p_i(p),
    .busy_o(busy), .done_o(done), .s_o(s));

  gf_matmul_scheduler #(.N(8), .ROW_A(1), .COL_A(1), .COL_B(1)) u_dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .a_i(a1), .b_i(b1), .p_i(p1),
    .busy_o(busy1), .done_o(done1), .s_o(s1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Peasant multiply: multiplicand doubled and reduced each step.
  function automatic logic [7:0] gm(input logic [7:0] x, input logic [7:0] y, input logic [8:0] pp);
    logic [8:0] aa;
    logic [7:0] r;
    aa = {1'b0, x};
    r  = '0;
    for (int t = 0; t < 8; t++) begin
      if (y[t]) r = r ^ aa[7:0];
      aa = aa << 1;
      if (aa[8]) aa = aa ^ pp;
    end
    return r;
  endfunction

  function automatic logic [3:0][7:0] ref_mm(input logic [15:0][7:0] av, input logic [3:0][7:0] bv,
                                             input logic [8:0] pp);
    logic [3:0][7:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i] = '0;
      for (int k = 0; k < 4; k++) r[i] = r[i] ^ gm(av[i*4+k], bv[k], pp);
    end
    return r;
  endfunction

  task automatic run4(input logic [15:0][7:0] av, input logic [3:0][7:0] bv, input logic [8:0] pv,
                      input bit scramble, output int lat, output int nb);
    @(posedge clk); #1;
    a = av; b = bv; p = pv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    nb  = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) nb++;
      if (scramble && lat == 5) begin
        a = {$urandom, $urandom, $urandom, $urandom};
        b = $urandom;
        p = {1'b1, 8'($urandom)};
      end
    end
  endtask

  task automatic run1(input logic [7:0] av, input logic [7:0] bv, output int lat);
    @(posedge clk); #1;
    a1[0] = av; b1[0] = bv; p1 = 9'h11B; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    lat = 1;
    while (!done1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  logic [15:0][7:0] aes_a;
  logic [15:0][7:0] id_a;
  logic [3:0][7:0]  bv, exp_s;
  logic [15:0][7:0] av;
  logic [8:0]       pv;
  logic [8:0]       plist [3];
  int lat, nb, cnt, ovl, ndone;

  initial begin
    plist[0] = 9'h11B; plist[1] = 9'h11D; plist[2] = 9'h12B;
    aes_a = {8'h02, 8'h01, 8'h01, 8'h03,  8'h03, 8'h02, 8'h01, 8'h01,
             8'h01, 8'h03, 8'h02, 8'h01,  8'h01, 8'h01, 8'h03, 8'h02};
    id_a = '0;
    for (int i = 0; i < 4; i++) id_a[i*4+i] = 8'h01;

    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    a = '0; b = '0; p = '0; a1 = '0; b1 = '0; p1 = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_s", s, 0);
    @(negedge clk) rst = 1'b0;

    // AES MixColumns columns
    run4(aes_a, {8'h45, 8'h53, 8'h13, 8'hDB}, 9'h11B, 1'b0, lat, nb);
    check("aes1_lat", lat, 17);
    check("aes1_busy_cycles", nb, 16);
    check("aes1_s", s, {8'hBC, 8'hA1, 8'h4D, 8'h8E});
    run4(aes_a, {8'h5C, 8'h22, 8'h0A, 8'hF2}, 9'h11B, 1'b0, lat, nb);
    check("aes2_lat", lat, 17);
    check("aes2_s", s, {8'h9D, 8'h58, 8'hDC, 8'h9F});

    // 1x1 degenerate
    run1(8'h57, 8'h83, lat);
    check("x1_lat", lat, 2);
    check("x1_s", s1, 8'hC1);
    run1(8'h00, 8'h83, lat);
    check("x1_zero", s1, 8'h00);
    run1(8'h01, 8'hFF, lat);
    check("x1_one", s1, 8'hFF);

    // Identity with operands scrambled mid-run
    for (int r = 0; r < 4; r++) begin
      bv = $urandom;
      run4(id_a, bv, plist[r % 3], (r >= 2), lat, nb);
      check("ident_lat", lat, 17);
      check("ident_s", s, bv);
    end

    // Reference sweep
    for (int r = 0; r < 200; r++) begin
      av = {$urandom, $urandom, $urandom, $urandom};
      bv = $urandom;
      pv = plist[$urandom_range(0, 2)];
      exp_s = ref_mm(av, bv, pv);
      run4(av, bv, pv, 1'b0, lat, nb);
      check("sweep_s", s, exp_s);
    end

    // Start held high
    start = 1'b1;
    ovl = 0;
    cnt = 0;
    while (!done && cnt < 60) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("held_first_done", done, 1);
    for (int n = 0; n < 3; n++) begin
      cnt = 0;
      do begin
        @(posedge clk); #1;
        cnt++;
        if (busy && done) ovl++;
      end while (!done && cnt < 40);
      check("held_period", cnt, 18);
    end
    check("held_overlap", ovl, 0);
    start = 1'b0;

    // Async reset in RUN cycle 7
    bv = $urandom | 32'h01010101;
    run4(id_a, bv, 9'h11B, 1'b0, lat, nb);
    check("pre_rst_s", s, bv);
    @(posedge clk); #1;
    a = aes_a; b = {8'h45, 8'h53, 8'h13, 8'hDB}; p = 9'h11B; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #4 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_s", s, 0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    ndone = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("no_done_after_rst", ndone, 0);
    run4(aes_a, {8'h45, 8'h53, 8'h13, 8'hDB}, 9'h11B, 1'b0, lat, nb);
    check("post_rst_lat", lat, 17);
    check("post_rst_s", s, {8'hBC, 8'hA1, 8'h4D, 8'h8E});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
